fp_mult_pipe: RTL and testbench

//  Parametrised, pipelined IEEE-754-style floating-point multiplier for the filter datapath.

---
 rtl/fp_mult_pipe.sv | 150 +++++++++++++++
 tb/tb_fp_mult_pipe.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: 3-stage pipelined floating-point multiplier (float16 by default) with
// round-to-nearest-even, overflow saturation to Inf, flush-to-zero and NaN/Inf handling.
module fp_mult_pipe #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     in_a,
    input  logic [EXP_W+MAN_W:0]     in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     out_data,
    output logic                     out_ovf,
    output logic                     out_udf,
    output logic                     out_inv
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int EW   = EXP_W + 2;
    localparam int SW   = MAN_W + 1;
    localparam int PW   = 2 * SW;
    localparam int BIAS = (2 ** (EXP_W - 1)) - 1;
    localparam logic [EXP_W-1:0]     EMAX   = {EXP_W{1'b1}};
    localparam logic signed [EW-1:0] BIAS_S = EW'(BIAS);
    localparam logic signed [EW-1:0] EMAX_S = {2'b00, EMAX};
    localparam logic signed [EW-1:0] ONE_S  = {{(EW-1){1'b0}}, 1'b1};
    localparam logic signed [EW-1:0] ZERO_S = {EW{1'b0}};
    localparam logic [W-1:0]         QNAN   = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

    // Class vector bits: [3] NaN result, [2] Inf*0, [1] Inf operand, [0] zero operand
    logic                   advance_s;
    logic                   a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s, inv_s;
    logic [3:0]             cls_s;
    logic signed [EW-1:0]   e1_s;

    logic                   v1_r, v2_r;
    logic                   s1_sign_r, s2_sign_r;
    logic [3:0]             s1_cls_r, s2_cls_r;
    logic signed [EW-1:0]   s1_exp_r, s2_exp_r;
    logic [SW-1:0]          s1_ma_r, s1_mb_r;
    logic [PW-1:0]          s2_prod_r;

    logic [PW-2:0]          norm_s;
    logic signed [EW-1:0]   e_n_s, e_f_s;
    logic [MAN_W-1:0]       man_k_s, man_f_s;
    logic [MAN_W:0]         man_r_s;
    logic                   guard_s, sticky_s, rnd_s;
    logic [W-1:0]           res_data_s;
    logic                   res_ovf_s, res_udf_s, res_inv_s;

    assign advance_s = !out_valid || out_ready;
    assign in_ready  = advance_s;

    // Stage 1 combinational: classify operands and form the biased exponent sum
    always_comb begin
        a_zero_s = (in_a[W-2 -: EXP_W] == {EXP_W{1'b0}});
        b_zero_s = (in_b[W-2 -: EXP_W] == {EXP_W{1'b0}});
        a_inf_s  = (in_a[W-2 -: EXP_W] == EMAX) && (in_a[MAN_W-1:0] == {MAN_W{1'b0}});
        b_inf_s  = (in_b[W-2 -: EXP_W] == EMAX) && (in_b[MAN_W-1:0] == {MAN_W{1'b0}});
        a_nan_s  = (in_a[W-2 -: EXP_W] == EMAX) && (in_a[MAN_W-1:0] != {MAN_W{1'b0}});
        b_nan_s  = (in_b[W-2 -: EXP_W] == EMAX) && (in_b[MAN_W-1:0] != {MAN_W{1'b0}});
        inv_s    = (a_inf_s && b_zero_s) || (b_inf_s && a_zero_s);
        cls_s    = {a_nan_s || b_nan_s || inv_s, inv_s, a_inf_s || b_inf_s, a_zero_s || b_zero_s};
        e1_s     = $signed({2'b00, in_a[W-2 -: EXP_W]}) + $signed({2'b00, in_b[W-2 -: EXP_W]}) - BIAS_S;
    end

    // Stage 3 combinational: normalise, round to nearest-even, then apply result precedence
    always_comb begin
        if (s2_prod_r[PW-1]) begin
            norm_s = s2_prod_r[PW-2:0];
            e_n_s  = s2_exp_r + ONE_S;
        end else begin
            norm_s = {s2_prod_r[PW-3:0], 1'b0};
            e_n_s  = s2_exp_r;
        end
        man_k_s  = norm_s[PW-2 -: MAN_W];
        guard_s  = norm_s[PW-2-MAN_W];
        sticky_s = |norm_s[PW-3-MAN_W:0];
        rnd_s    = guard_s && (sticky_s || man_k_s[0]);
        man_r_s  = {1'b0, man_k_s} + {{MAN_W{1'b0}}, rnd_s};
        if (man_r_s[MAN_W]) begin
            man_f_s = {MAN_W{1'b0}};
            e_f_s   = e_n_s + ONE_S;
        end else begin
            man_f_s = man_r_s[MAN_W-1:0];
            e_f_s   = e_n_s;
        end
        res_ovf_s  = 1'b0;
        res_udf_s  = 1'b0;
        res_inv_s  = 1'b0;
        res_data_s = {W{1'b0}};
        if (s2_cls_r[3]) begin
            res_data_s = QNAN;
            res_inv_s  = s2_cls_r[2];
        end else if (s2_cls_r[1]) begin
            res_data_s = {s2_sign_r, EMAX, {MAN_W{1'b0}}};
        end else if (s2_cls_r[0]) begin
            res_data_s = {s2_sign_r, {(EXP_W+MAN_W){1'b0}}};
        end else if (e_f_s >= EMAX_S) begin
            res_data_s = {s2_sign_r, EMAX, {MAN_W{1'b0}}};
            res_ovf_s  = 1'b1;
        end else if (e_f_s <= ZERO_S) begin
            res_data_s = {s2_sign_r, {(EXP_W+MAN_W){1'b0}}};
            res_udf_s  = 1'b1;
        end else begin
            res_data_s = {s2_sign_r, e_f_s[EXP_W-1:0], man_f_s};
        end
    end

    // Pipeline registers: every stage moves together on advance and holds otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r      <= 1'b0;
            v2_r      <= 1'b0;
            out_valid <= 1'b0;
            s1_sign_r <= 1'b0;
            s1_cls_r  <= 4'b0000;
            s1_exp_r  <= ZERO_S;
            s1_ma_r   <= {SW{1'b0}};
            s1_mb_r   <= {SW{1'b0}};
            s2_sign_r <= 1'b0;
            s2_cls_r  <= 4'b0000;
            s2_exp_r  <= ZERO_S;
            s2_prod_r <= {PW{1'b0}};
            out_data  <= {W{1'b0}};
            out_ovf   <= 1'b0;
            out_udf   <= 1'b0;
            out_inv   <= 1'b0;
        end else if (advance_s) begin
            v1_r      <= in_valid;
            s1_sign_r <= in_a[W-1] ^ in_b[W-1];
            s1_cls_r  <= cls_s;
            s1_exp_r  <= e1_s;
            s1_ma_r   <= {1'b1, in_a[MAN_W-1:0]};
            s1_mb_r   <= {1'b1, in_b[MAN_W-1:0]};
            v2_r      <= v1_r;
            s2_sign_r <= s1_sign_r;
            s2_cls_r  <= s1_cls_r;
            s2_exp_r  <= s1_exp_r;
            s2_prod_r <= {{SW{1'b0}}, s1_ma_r} * {{SW{1'b0}}, s1_mb_r};
            out_valid <= v2_r;
            out_data  <= v2_r ? res_data_s : {W{1'b0}};
            out_ovf   <= v2_r && res_ovf_s;
            out_udf   <= v2_r && res_udf_s;
            out_inv   <= v2_r && res_inv_s;
        end
    end
endmodule

// File: tb/tb_fp_mult_pipe.sv
// Scoreboard bench for fp_mult_pipe (float16): directed specials/rounding/range cases,
// a backpressured random stream and a mid-flight reset.
module tb_fp_mult_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = 16'h0000;
    logic [15:0] in_b = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        out_ovf, out_udf, out_inv;

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          n_res = 0;
    bit          chk_lat = 1'b0;
    bit          saw_block = 1'b0;
    bit          prev_stall = 1'b0;
    logic [18:0] prev_o = 19'd0;
    logic [18:0] exp_q[$];
    int          acc_q[$];
    logic [18:0] ev;
    int          av;

    fp_mult_pipe #(.EXP_W(5), .MAN_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ovf(out_ovf), .out_udf(out_udf), .out_inv(out_inv)
    );

    always #5 clk = ~clk;

    // Cycle counter used to timestamp accepts and measure latency
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference float16 product as {ovf, udf, inv, data}
    function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b);
        int   ea = a[14:10];
        int   eb = b[14:10];
        int   ma = a[9:0];
        int   mb = b[9:0];
        logic s  = a[15] ^ b[15];
        bit   az = (ea == 0);
        bit   bz = (eb == 0);
        bit   ai = (ea == 31) && (ma == 0);
        bit   bi = (eb == 31) && (mb == 0);
        bit   an = (ea == 31) && (ma != 0);
        bit   bn = (eb == 31) && (mb != 0);
        int   prod, sh, e, q, r, half;
        if (an || bn || (ai && bz) || (bi && az))
            return {2'b00, ((ai && bz) || (bi && az)), 16'h7E00};
        if (ai || bi) return {3'b000, s, 5'd31, 10'd0};
        if (az || bz) return {3'b000, s, 15'd0};
        prod = (1024 + ma) * (1024 + mb);
        if (prod >= (1 << 21)) begin sh = 11; e = ea + eb - 14; end
        else begin sh = 10; e = ea + eb - 15; end
        q    = prod >> sh;
        r    = prod - (q << sh);
        half = 1 << (sh - 1);
        if (r > half || (r == half && (q % 2) == 1)) q++;
        if (q == 2048) begin q = 1024; e++; end
        if (e >= 31) return {3'b100, s, 5'd31, 10'd0};
        if (e <= 0) return {3'b010, s, 15'd0};
        return {3'b000, s, e[4:0], q[9:0]};
    endfunction

    // Present one operand pair, wait (bounded) for acceptance and log the expected result
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [18:0] exp);
        int k = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        @(negedge clk);
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) check("accept_timeout", in_ready, 1'b1);
        else begin
            exp_q.push_back(exp);
            acc_q.push_back(cyc);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_q.size() != 0 || out_valid) && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    // Output monitor: pops the scoreboard on each new result and checks hold during stalls
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            acc_q.delete();
            prev_stall <= 1'b0;
        end else begin
            if (in_valid && !in_ready) saw_block <= 1'b1;
            if (prev_stall) begin
                check("stall_hold_valid", out_valid, 1'b1);
                check("stall_hold_data", {out_ovf, out_udf, out_inv, out_data}, prev_o);
            end
            if (out_valid && !prev_stall) begin
                if (exp_q.size() == 0) check("spurious_result", out_valid, 1'b0);
                else begin
                    ev = exp_q.pop_front();
                    av = acc_q.pop_front();
                    n_res <= n_res + 1;
                    check("result", {out_ovf, out_udf, out_inv, out_data}, ev);
                    if (chk_lat) check("latency", cyc - av, 3);
                end
            end else if (!out_valid) begin
                check("idle_flags", {out_ovf, out_udf, out_inv}, 3'b000);
            end
            prev_stall <= out_valid && !out_ready;
            prev_o     <= {out_ovf, out_udf, out_inv, out_data};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra[8];
        logic [15:0] rb[8];
        int          base;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_data", out_data, 16'h0000);
        check("rst_flags", {out_ovf, out_udf, out_inv}, 3'b000);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases streamed back-to-back with latency checking
        chk_lat = 1'b1;
        issue(16'h4000, 16'h4200, {3'b000, 16'h4600});
        issue(16'hC000, 16'h4200, {3'b000, 16'hC600});
        issue(16'h3C01, 16'h3C01, {3'b000, 16'h3C02});
        issue(16'h3C01, 16'h3E00, {3'b000, 16'h3E02});
        issue(16'h7C00, 16'h0000, {3'b001, 16'h7E00});
        issue(16'h7C00, 16'hC000, {3'b000, 16'hFC00});
        issue(16'h0000, 16'h8000, {3'b000, 16'h8000});
        issue(16'h7BFF, 16'h7BFF, {3'b100, 16'h7C00});
        issue(16'h0400, 16'h0400, {3'b010, 16'h0000});
        issue(16'h7E01, 16'h3C00, {3'b000, 16'h7E00});
        drain();

        // Backpressure: 8 random pairs with a 4-cycle out_ready stall mid-stream
        chk_lat = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin
                ra[i] = 16'($urandom());
                rb[i] = 16'($urandom());
            end else begin
                ra[i] = {1'($urandom_range(1, 0)), 5'($urandom_range(22, 8)), 10'($urandom())};
                rb[i] = {1'($urandom_range(1, 0)), 5'($urandom_range(22, 8)), 10'($urandom())};
            end
        end
        base = n_res;
        fork
            begin
                for (int i = 0; i < 8; i++) issue(ra[i], rb[i], model(ra[i], rb[i]));
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_result_count", n_res - base, 8);
        check("bp_in_ready_dropped", saw_block, 1'b1);

        // Reset with three operations in flight
        chk_lat = 1'b1;
        issue(16'h4400, 16'h4400, model(16'h4400, 16'h4400));
        issue(16'h3800, 16'h4000, model(16'h3800, 16'h4000));
        issue(16'hBC00, 16'h3C00, model(16'hBC00, 16'h3C00));
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_out_data", out_data, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("post_rst_quiet", out_valid, 1'b0);
        issue(16'h4000, 16'h4200, {3'b000, 16'h4600});
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
